// File: rtl/sram_pkg.sv
// Shared types and defaults for the 2K x 16 shared-bus SRAM responder.
// No logic, so no latency or backpressure.
package sram_pkg;

    localparam int              ADDR_W_DEF     = 11;
    localparam int              DATA_W_DEF     = 16;
    localparam logic [15:0]     INIT_VALUE_DEF = 16'h0000;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/sram_array_sp.sv
// Single-port storage: one write port and one registered read port.
// Write commits at the edge; read data appears after the edge. There is no backpressure.
module sram_array_sp
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset; the owner sweeps them after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram2k16_responder.sv
// Memory-side responder: clears the array after reset and then serves bus reads and writes.
// Read data is on the bus one edge after the request; a read->write switch costs one dropped cycle.
module sram2k16_responder
    import sram_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VALUE = INIT_VALUE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] adx,
    input  logic              wr_n,
    inout  wire  [DATA_W-1:0] data,
    output logic              ready,
    output logic              wr_dropped
);

    localparam int              DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              drive_en_q, drive_en_d;
    logic              ready_q, ready_d;
    logic              drop_q, drop_d;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            drive_en_q <= 1'b0;
            ready_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drive_en_q <= drive_en_d;
            ready_q    <= ready_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drive_en_d = drive_en_q;
        ready_d    = ready_q;
        drop_d     = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_waddr  = adx;
        mem_wdata  = data;

        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[ADDR_W-1:0];
                mem_wdata = INIT_VALUE;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (!wr_n) begin
                    mem_we = 1'b1;
                end else begin
                    mem_re     = 1'b1;
                    drive_en_d = 1'b1;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                if (wr_n) begin
                    mem_re = 1'b1;
                end else begin
                    // Bus still carries our read data at this edge, so the write is refused.
                    drive_en_d = 1'b0;
                    drop_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    sram_array_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we & ~rst),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (adx),
        .rdata (rdata)
    );

    assign data       = drive_en_q ? rdata : 'z;
    assign ready      = ready_q;
    assign wr_dropped = drop_q;

endmodule

// File: tb/tb_sram2k16_responder.sv
// Bench for sram2k16_responder: reset sweep timing, table-driven bus traffic, mid-sweep reset.
module tb_sram2k16_responder;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;
    localparam int   NV = 26;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] adx;
    logic        wr_n;
    logic [15:0] tb_dat;
    logic        tb_oe;
    wire  [15:0] data_bus;
    logic        ready;
    logic        wr_dropped;

    always #5 clk = ~clk;

    assign data_bus = tb_oe ? tb_dat : 'z;

    sram2k16_responder dut (
        .clk        (clk),
        .rst        (rst),
        .adx        (adx),
        .wr_n       (wr_n),
        .data       (data_bus),
        .ready      (ready),
        .wr_dropped (wr_dropped)
    );

    typedef struct packed {
        logic        wr_n;
        logic [10:0] adx;
        logic [15:0] dat;
        logic        exp_hiz;
        logic [15:0] exp_bus;
        logic        exp_drop;
    } vec_t;

    typedef struct packed {
        logic        hiz;
        logic [15:0] bus;
        logic        drop;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [NV];
    exp_t sb_q [$];

    function automatic vec_t mk(input logic w, input logic [10:0] a, input logic [15:0] d,
                                input logic hz, input logic [15:0] eb, input logic dr);
        vec_t v;
        v.wr_n     = w;
        v.adx      = a;
        v.dat      = d;
        v.exp_hiz  = hz;
        v.exp_bus  = eb;
        v.exp_drop = dr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive two complementary patterns; a released bus reads back exactly what the bench drives.
    task automatic check_hiz(input string name);
        logic        save_oe;
        logic [15:0] save_dat;
        logic [15:0] a;
        logic [15:0] b;
        save_oe  = tb_oe;
        save_dat = tb_dat;
        tb_oe    = 1'b1;
        tb_dat   = 16'hA5C3;
        #1 a     = data_bus;
        tb_dat   = 16'h5A3C;
        #1 b     = data_bus;
        tb_oe    = save_oe;
        tb_dat   = save_dat;
        n_tests++;
        if (a !== 16'hA5C3 || b !== 16'h5A3C) begin
            n_fail++;
            $display("FAIL %s: bus not released, read %h/%h while bench drove a5c3/5a3c", name, a, b);
        end
    endtask

    // Called just after a negedge; the request is sampled at the following posedge.
    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        rst    = 1'b0;
        wr_n   = v.wr_n;
        adx    = v.adx;
        tb_dat = v.dat;
        tb_oe  = ~v.wr_n;
        sb_q.push_back({v.exp_hiz, v.exp_bus, v.exp_drop});
        @(negedge clk);
        e = sb_q.pop_front();
        check({name, " wr_dropped"}, {31'd0, wr_dropped}, {31'd0, e.drop});
        if (e.hiz) begin
            check_hiz({name, " bus hiz"});
        end else begin
            check({name, " bus data"}, {16'd0, data_bus}, {16'd0, e.bus});
        end
    endtask

    task automatic reset_and_sweep(input int cut_at, input string tag);
        int first;
        rst   = 1'b1;
        wr_n  = 1'b1;
        tb_oe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check({tag, " ready after reset"}, {31'd0, ready}, 32'd0);
        check({tag, " drop after reset"}, {31'd0, wr_dropped}, 32'd0);
        check_hiz({tag, " bus after reset"});
        if (cut_at > 0) begin
            repeat (cut_at - 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check({tag, " ready after mid-sweep reset"}, {31'd0, ready}, 32'd0);
        end
        first = 0;
        for (int k = 1; k <= 3000; k++) begin
            // Scribble on words the sweep has already cleared; these must be ignored.
            wr_n   = 1'b0;
            tb_oe  = 1'b1;
            adx    = (k > 1) ? 11'(k - 2) : 11'd0;
            tb_dat = 16'hFFFF;
            @(negedge clk);
            if (k == 1 || k == 1500) begin
                check_hiz($sformatf("%s bus during sweep cycle %0d", tag, k));
            end
            if (ready) begin
                first = k;
                break;
            end
        end
        wr_n  = 1'b1;
        tb_oe = 1'b0;
        check({tag, " sweep length"}, first, 32'd2048);
    endtask

    initial begin
        rst    = 1'b1;
        wr_n   = 1'b1;
        adx    = '0;
        tb_dat = '0;
        tb_oe  = 1'b0;

        vecs[0]  = mk(WR, 11'h005, 16'h007A, 1'b1, 16'h0000, 1'b0);
        vecs[1]  = mk(RD, 11'h005, 16'h0000, 1'b0, 16'h007A, 1'b0);
        vecs[2]  = mk(RD, 11'h3A5, 16'h0000, 1'b0, 16'h0000, 1'b0);
        vecs[3]  = mk(WR, 11'h005, 16'h1234, 1'b1, 16'h0000, 1'b1);
        vecs[4]  = mk(WR, 11'h005, 16'h1234, 1'b1, 16'h0000, 1'b0);
        vecs[5]  = mk(RD, 11'h005, 16'h0000, 1'b0, 16'h1234, 1'b0);
        vecs[6]  = mk(WR, 11'h000, 16'h007F, 1'b1, 16'h0000, 1'b1);
        vecs[7]  = mk(WR, 11'h000, 16'h007F, 1'b1, 16'h0000, 1'b0);
        vecs[8]  = mk(WR, 11'h001, 16'h007E, 1'b1, 16'h0000, 1'b0);
        vecs[9]  = mk(WR, 11'h002, 16'h007D, 1'b1, 16'h0000, 1'b0);
        vecs[10] = mk(WR, 11'h003, 16'h007C, 1'b1, 16'h0000, 1'b0);
        vecs[11] = mk(RD, 11'h000, 16'h0000, 1'b0, 16'h007F, 1'b0);
        vecs[12] = mk(RD, 11'h001, 16'h0000, 1'b0, 16'h007E, 1'b0);
        vecs[13] = mk(RD, 11'h002, 16'h0000, 1'b0, 16'h007D, 1'b0);
        vecs[14] = mk(RD, 11'h003, 16'h0000, 1'b0, 16'h007C, 1'b0);
        vecs[15] = mk(WR, 11'h7FF, 16'hBEEF, 1'b1, 16'h0000, 1'b1);
        vecs[16] = mk(WR, 11'h7FF, 16'hBEEF, 1'b1, 16'h0000, 1'b0);
        vecs[17] = mk(WR, 11'h000, 16'hCAFE, 1'b1, 16'h0000, 1'b0);
        vecs[18] = mk(RD, 11'h7FF, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
        vecs[19] = mk(RD, 11'h000, 16'h0000, 1'b0, 16'hCAFE, 1'b0);
        vecs[20] = mk(WR, 11'h400, 16'h5555, 1'b1, 16'h0000, 1'b1);
        vecs[21] = mk(RD, 11'h400, 16'h0000, 1'b0, 16'h0000, 1'b0);
        vecs[22] = mk(WR, 11'h400, 16'h5555, 1'b1, 16'h0000, 1'b1);
        vecs[23] = mk(WR, 11'h400, 16'h5555, 1'b1, 16'h0000, 1'b0);
        vecs[24] = mk(RD, 11'h400, 16'h0000, 1'b0, 16'h5555, 1'b0);
        vecs[25] = mk(RD, 11'h001, 16'h0000, 1'b0, 16'h007E, 1'b0);

        repeat (3) @(negedge clk);
        reset_and_sweep(0, "sweep");

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        reset_and_sweep(1000, "mid_reset");
        run_vec(mk(RD, 11'h005, 16'h0000, 1'b0, 16'h0000, 1'b0), "post_reset rd 005");
        run_vec(mk(RD, 11'h7FF, 16'h0000, 1'b0, 16'h0000, 1'b0), "post_reset rd 7ff");
        run_vec(mk(RD, 11'h3A5, 16'h0000, 1'b0, 16'h0000, 1'b0), "post_reset rd 3a5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
